hex_scan_disp: RTL and testbench

HEX_SCAN_DISP -- requirements
Module: hex_scan_disp

---
 rtl/hex_scan_disp.sv | 159 +++++++++++++++
 tb/tb_hex_scan_disp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_disp.sv
// Multiplexed 7-segment display of the most recent hex results.
// A shift-register history feeds a time-sliced digit scanner; every
// digit slot opens with a short all-off guard period to suppress ghosting.
// The decimal point on digit 0 flashes for a while after each new result.
module hex_scan_disp #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 16,
  parameter int FLASH_CYCLES = 25000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  result_valid,
  input  logic [3:0]            result,
  input  logic                  hold,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_en
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int FL_W  = $clog2(FLASH_CYCLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_V  = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_DIGITS);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_CYCLES);

  // "Off" levels of the physical outputs for the selected polarity.
  localparam logic                  INV      = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF  = {7{INV}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{INV}};

  // Hex digit to active-high segment pattern, bit order gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [3:0]            hist_q [NUM_DIGITS];
  logic [3:0]            hist_d [NUM_DIGITS];
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [FL_W-1:0]       flash_q,  flash_d;
  logic [PRE_W-1:0]      pre_q,    pre_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [6:0]            seg_q,    seg_d;
  logic                  dp_q,     dp_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

  // Active-high view of the outputs before polarity is applied.
  logic [6:0]            seg_a;
  logic                  dp_a;
  logic [NUM_DIGITS-1:0] dig_a;
  logic                  shown;

  // History, loaded count and flash countdown; clear beats a new result,
  // hold only drops results and never stops the countdown.
  always_comb begin
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    flash_d = (flash_q != '0) ? flash_q - FL_W'(1) : flash_q;
    if (clear) begin
      cnt_d   = '0;
      flash_d = '0;
    end else if (result_valid && !hold) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        hist_d[i] = hist_q[i-1];
      end
      hist_d[0] = result;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      flash_d = FL_LOAD;
    end
  end

  // Scan prescaler and digit index; index steps once per prescaler wrap.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Output decode from the current scan position and history, then polarity.
  always_comb begin
    seg_a = '0;
    dp_a  = 1'b0;
    dig_a = '0;
    shown = (int'(idx_q) < int'(cnt_q));
    if (pre_q >= GUARD_V) begin
      dig_a = NUM_DIGITS'(1) << idx_q;
      if (shown) begin
        seg_a = hex7(hist_q[idx_q]);
        dp_a  = (idx_q == '0) && (flash_q != '0);
      end
    end
    seg_d    = INV ? ~seg_a : seg_a;
    dp_d     = INV ? ~dp_a  : dp_a;
    dig_en_d = INV ? ~dig_a : dig_a;
  end

  // State and output registers; reset empties the display and restarts the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= '0;
      end
      cnt_q    <= '0;
      flash_q  <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= INV;
      dig_en_q <= DIG_OFF;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= hist_d[i];
      end
      cnt_q    <= cnt_d;
      flash_q  <= flash_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign dig_en = dig_en_q;

endmodule

// File: tb/tb_hex_scan_disp.sv
// Directed bench for hex_scan_disp with a small scan (4 digits, 4 cycles
// per slot, 1 guard cycle, 10 flash cycles). An active-high and an
// active-low instance share the stimulus.
module tb_hex_scan_disp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       result_valid = 1'b0;
  logic [3:0] result = 4'h0;
  logic       hold = 1'b0;
  logic       clear = 1'b0;

  logic [6:0] seg,    seg_n;
  logic       dp,     dp_n;
  logic [3:0] dig_en, dig_en_n;

  int total = 0;
  int bad   = 0;
  int k     = 0;   // edges since reset release

  always #5 clk = ~clk;

  hex_scan_disp #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .FLASH_CYCLES(10), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
    .hold(hold), .clear(clear), .seg(seg), .dp(dp), .dig_en(dig_en)
  );

  hex_scan_disp #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .FLASH_CYCLES(10), .ACTIVE_LOW(1)
  ) dut_n (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
    .hold(hold), .clear(clear), .seg(seg_n), .dp(dp_n), .dig_en(dig_en_n)
  );

  typedef struct {
    logic       rv;
    logic [3:0] res;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
  } vec_t;

  vec_t tbl [16];

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string nm, input logic [6:0] es, input logic ed,
                       input logic [3:0] eg);
    total++;
    if (seg !== es || dp !== ed || dig_en !== eg ||
        seg_n !== ~es || dp_n !== ~ed || dig_en_n !== ~eg) begin
      bad++;
      $display("FAIL %s k=%0d got seg=%h dp=%b dig=%b low:seg=%h dp=%b dig=%b need seg=%h dp=%b dig=%b",
               nm, k, seg, dp, dig_en, seg_n, dp_n, dig_en_n, es, ed, eg);
    end
  endtask

  // One cycle of the free-running scan: digit segments s0..s3 (0 = blank),
  // dp expected on shown digit 0 while k <= dp_until.
  task automatic check_at(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3, input int dp_until);
    logic [6:0] s [4];
    int p, idx, pre;
    logic [6:0] es;
    logic       ed;
    logic [3:0] eg;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    step();
    p   = (k - 1) % 16;
    idx = p / 4;
    pre = p % 4;
    if (pre == 0) begin
      es = 7'h00; ed = 1'b0; eg = 4'b0000;
    end else begin
      es = s[idx];
      ed = (idx == 0) && (s[0] != 7'h00) && (k <= dp_until);
      eg = 4'b0001 << idx;
    end
    check(nm, es, ed, eg);
  endtask

  // Checks every cycle up to the end of the current scan round.
  task automatic scan_run(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3, input int dp_until);
    do begin
      check_at(nm, s0, s1, s2, s3, dp_until);
    end while (k % 16 != 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; result_valid = 1'b0; hold = 1'b0; clear = 1'b0; result = 4'h0;
    step();
    step();
    check("reset_state", 7'h00, 1'b0, 4'b0000);
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    // Idle scan after reset: one round of 16 cycles, applied twice.
    tbl[0]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0001};
    tbl[2]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0001};
    tbl[3]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0001};
    tbl[4]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0010};
    tbl[6]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0010};
    tbl[7]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0010};
    tbl[8]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0100};
    tbl[10] = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0100};
    tbl[11] = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0100};
    tbl[12] = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b0000};
    tbl[13] = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b1000};
    tbl[14] = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b1000};
    tbl[15] = '{1'b0, 4'h0, 7'h00, 1'b0, 4'b1000};

    do_reset();
    for (int i = 0; i < 32; i++) begin
      result_valid = tbl[i % 16].rv;
      result       = tbl[i % 16].res;
      step();
      check("idle_scan", tbl[i % 16].seg, tbl[i % 16].dp, tbl[i % 16].dig);
    end
    result_valid = 1'b0;

    // Two results: 3 then A; the first shows on digit 0 one cycle later.
    do_reset();
    result_valid = 1'b1; result = 4'h3;
    step();
    check("first_edge", 7'h00, 1'b0, 4'b0000);
    result = 4'hA;
    step();
    check("first_res", 7'h4F, 1'b1, 4'b0001);
    result_valid = 1'b0;
    scan_run("two_res", 7'h77, 7'h4F, 7'h00, 7'h00, 12);
    scan_run("two_res_r2", 7'h77, 7'h4F, 7'h00, 7'h00, 12);

    // Five results 1..5 back to back; history keeps the newest four.
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      result_valid = 1'b1; result = 4'(v);
      step();
    end
    result_valid = 1'b0;
    scan_run("five_res", 7'h6D, 7'h66, 7'h4F, 7'h5B, 15);
    scan_run("five_res_r2", 7'h6D, 7'h66, 7'h4F, 7'h5B, 15);

    // Held strobe is dropped; scan and display keep running under hold.
    hold = 1'b1; result_valid = 1'b1; result = 4'h7;
    step();
    check("hold_edge", 7'h00, 1'b0, 4'b0000);
    result_valid = 1'b0;
    scan_run("hold_keep", 7'h6D, 7'h66, 7'h4F, 7'h5B, 15);
    hold = 1'b0;

    // Clear together with a strobe: clear wins, everything blank.
    clear = 1'b1; result_valid = 1'b1; result = 4'h9;
    step();
    check("clear_edge", 7'h00, 1'b0, 4'b0000);
    clear = 1'b0; result_valid = 1'b0;
    scan_run("cleared", 7'h00, 7'h00, 7'h00, 7'h00, 0);
    scan_run("cleared_r2", 7'h00, 7'h00, 7'h00, 7'h00, 0);

    // Flash window: strobe at edge 8, dp lit on digit 0 through k=18 only.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      check_at("pre_flash", 7'h00, 7'h00, 7'h00, 7'h00, 0);
    end
    result_valid = 1'b1; result = 4'h8;
    check_at("flash_edge", 7'h00, 7'h00, 7'h00, 7'h00, 0);
    result_valid = 1'b0;
    scan_run("flash", 7'h7F, 7'h00, 7'h00, 7'h00, 18);
    scan_run("flash_r2", 7'h7F, 7'h00, 7'h00, 7'h00, 18);
    scan_run("flash_r3", 7'h7F, 7'h00, 7'h00, 7'h00, 18);

    // Reset in the middle of slot 1 with three results loaded.
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      result_valid = 1'b1; result = 4'(v);
      step();
    end
    result_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("mid_rst", 7'h00, 1'b0, 4'b0000);
    rst = 1'b0;
    k = 0;
    scan_run("after_rst", 7'h00, 7'h00, 7'h00, 7'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
